card_dealer: RTL and testbench

//  Upstream stage of the card 7-segment decoders. Holds a free-running card

---
 rtl/card_dealer.sv | 121 ++++++++++++
 tb/tb_card_dealer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// Card dealer: free-running rank counter acting as the deck, captured into six
// card slots in baccarat order (P1,D1,P2,D2,P3,D3) on each debounced press.
module card_dealer #(
  parameter int CARD_MAX       = 13,
  parameter int LOCKOUT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       deal_btn,
  input  logic       new_hand,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [2:0] deal_count,
  output logic       hand_full,
  output logic [3:0] card_value
);

  localparam int              LW        = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LW-1:0]   LOCK_INIT = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]      CMAX      = 4'(CARD_MAX);

  typedef enum logic [1:0] {IDLE, LOCK, FULL} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    card_reg;
  logic          btn_q_reg;
  logic [2:0]    count_reg, count_next;
  logic [LW-1:0] lock_reg, lock_next;
  logic [3:0]    slot_reg [6];
  logic          press;
  logic          deal_en;

  // The deck: keeps cycling regardless of hand state.
  always_ff @(posedge clk) begin
    if (reset)                card_reg <= 4'd1;
    else if (card_reg == CMAX) card_reg <= 4'd1;
    else                      card_reg <= card_reg + 4'd1;
  end

  // Reset to 1 so a button held through reset is not seen as a fresh press.
  always_ff @(posedge clk) begin
    if (reset) btn_q_reg <= 1'b1;
    else       btn_q_reg <= deal_btn;
  end

  assign press = deal_btn & ~btn_q_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= 3'd0;
      lock_reg  <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      lock_reg  <= lock_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    lock_next  = lock_reg;
    deal_en    = 1'b0;
    if (new_hand) begin
      state_next = IDLE;
      count_next = 3'd0;
      lock_next  = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (press) begin
            deal_en    = 1'b1;
            count_next = count_reg + 3'd1;
            if (count_reg == 3'd5) begin
              state_next = FULL;
            end else begin
              state_next = LOCK;
              lock_next  = LOCK_INIT;
            end
          end
        end
        LOCK: begin
          if (lock_reg == '0) state_next = IDLE;
          else                lock_next  = lock_reg - LW'(1);
        end
        FULL:    state_next = FULL;
        default: state_next = IDLE;
      endcase
    end
  end

  // Slot gi is filled by the deal made while deal_count == gi.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (reset || new_hand)
          slot_reg[gi] <= 4'd0;
        else if (deal_en && (count_reg == 3'(gi)))
          slot_reg[gi] <= card_reg;
      end
    end
  endgenerate

  always_comb begin
    pcard1     = slot_reg[0];
    dcard1     = slot_reg[1];
    pcard2     = slot_reg[2];
    dcard2     = slot_reg[3];
    pcard3     = slot_reg[4];
    dcard3     = slot_reg[5];
    deal_count = count_reg;
    hand_full  = (state_reg == FULL);
    card_value = card_reg;
  end

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: directed scenarios plus randomized
// traffic compared against a queue-based model of dealt cards.
module tb_card_dealer;

  localparam int CM = 13;
  localparam int LK = 4;

  logic       clk = 1'b0;
  logic       reset, deal_btn, new_hand;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, card_value;
  logic [2:0] deal_count;
  logic       hand_full;
  logic [31:0] dut_vec;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: cards dealt this hand, cycles since reset, button history, and
  // the first cycle at which a new press may be accepted.
  logic [3:0] cards[$];
  int         cyc = 0;
  bit         btn_prev = 1'b1;
  int         free_at = 0;

  card_dealer #(.CARD_MAX(CM), .LOCKOUT_CYCLES(LK)) dut (
    .clk(clk), .reset(reset), .deal_btn(deal_btn), .new_hand(new_hand),
    .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
    .dcard1(dcard1), .dcard2(dcard2), .dcard3(dcard3),
    .deal_count(deal_count), .hand_full(hand_full), .card_value(card_value)
  );

  always #5 clk = ~clk;

  assign dut_vec = {pcard1, dcard1, pcard2, dcard2, pcard3, dcard3,
                    deal_count, hand_full, card_value};

  function automatic logic [3:0] cur_val();
    return 4'((cyc % CM) + 1);
  endfunction

  function automatic logic [31:0] exp_vec();
    logic [3:0] s[6];
    for (int i = 0; i < 6; i++) s[i] = (i < cards.size()) ? cards[i] : 4'd0;
    return {s[0], s[1], s[2], s[3], s[4], s[5],
            3'(cards.size()), (cards.size() == 6), cur_val()};
  endfunction

  task automatic model_step();
    if (reset) begin
      cards.delete();
      cyc      = 0;
      btn_prev = 1'b1;
      free_at  = 0;
    end else begin
      if (new_hand) begin
        cards.delete();
        free_at = cyc + 1;
      end else if (deal_btn && !btn_prev && cards.size() < 6 && cyc >= free_at) begin
        cards.push_back(cur_val());
        free_at = cyc + 1 + LK;
      end
      btn_prev = deal_btn;
      cyc++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // One-cycle press sampled while card_value == v; returns at the cycle the
  // result is visible.
  task automatic press_at(input logic [3:0] v);
    bit ok = 1'b0;
    deal_btn = 1'b0;
    repeat (LK + 1) tick();
    for (int i = 0; i < 2 * CM && !ok; i++) begin
      if (cur_val() == v) ok = 1'b1;
      else tick();
    end
    n_checks++;
    if (!ok) $display("FAIL press_wait: value %0d never reached, got %0d", v, cur_val());
    else n_pass++;
    deal_btn = 1'b1;
    tick();
    deal_btn = 1'b0;
  endtask

  task automatic test_reset();
    deal_btn = 1'b0;
    new_hand = 1'b0;
    reset    = 1'b1;
    tick();
    tick();
    n_checks++;
    if (dut_vec !== 32'd1) $display("FAIL reset_state: got %h want %h", dut_vec, 32'd1);
    else n_pass++;
    reset = 1'b0;
    for (int k = 1; k < 20; k++) begin
      tick();
      n_checks++;
      if (card_value !== 4'((k % 13) + 1))
        $display("FAIL counter_seq[%0d]: got %0d want %0d", k, card_value, (k % 13) + 1);
      else n_pass++;
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL idle_run[%0d]: got %h want %h", k, dut_vec, exp_vec());
      else n_pass++;
    end
    $display("test_reset done: card_value=%0d deal_count=%0d", card_value, deal_count);
  endtask

  task automatic test_hold_through_reset();
    deal_btn = 1'b1;
    reset    = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    repeat (3) begin
      tick();
      n_checks++;
      if (deal_count !== 3'd0) $display("FAIL held_btn_no_deal: got %0d want 0", deal_count);
      else n_pass++;
    end
    deal_btn = 1'b0;
    press_at(4'd5);
    n_checks++;
    if (pcard1 !== 4'd5 || deal_count !== 3'd1)
      $display("FAIL held_then_press: got p1=%0d cnt=%0d want p1=5 cnt=1", pcard1, deal_count);
    else n_pass++;
    $display("test_hold_through_reset done: pcard1=%0d deal_count=%0d", pcard1, deal_count);
  endtask

  task automatic test_full_hand();
    logic [3:0] vals[6] = '{4'd1, 4'd13, 4'd7, 4'd2, 4'd9, 4'd4};
    logic [23:0] want;
    do_reset();
    foreach (vals[i]) begin
      press_at(vals[i]);
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL full_hand_deal[%0d]: got %h want %h", i, dut_vec, exp_vec());
      else n_pass++;
    end
    want = {4'd1, 4'd13, 4'd7, 4'd2, 4'd9, 4'd4};
    n_checks++;
    if (dut_vec[31:8] !== want || deal_count !== 3'd6 || hand_full !== 1'b1)
      $display("FAIL full_hand: got %h cnt=%0d full=%b want %h cnt=6 full=1",
               dut_vec[31:8], deal_count, hand_full, want);
    else n_pass++;
    press_at(4'd3);
    n_checks++;
    if (dut_vec[31:8] !== want || deal_count !== 3'd6 || hand_full !== 1'b1)
      $display("FAIL seventh_press: got %h cnt=%0d want %h cnt=6", dut_vec[31:8], deal_count, want);
    else n_pass++;
    $display("test_full_hand done: deal_count=%0d hand_full=%b", deal_count, hand_full);
  endtask

  task automatic test_lockout();
    logic [3:0] v;
    do_reset();
    press_at(4'd3);
    deal_btn = 1'b0;
    tick();
    tick();
    deal_btn = 1'b1;
    tick();
    deal_btn = 1'b0;
    tick();
    n_checks++;
    if (deal_count !== 3'd1) $display("FAIL lockout_press: got %0d want 1", deal_count);
    else n_pass++;
    v = cur_val();
    deal_btn = 1'b1;
    tick();
    deal_btn = 1'b0;
    n_checks++;
    if (deal_count !== 3'd2 || dcard1 !== v)
      $display("FAIL lockout_end_press: got cnt=%0d d1=%0d want cnt=2 d1=%0d", deal_count, dcard1, v);
    else n_pass++;
    tick();
    tick();
    deal_btn = 1'b1;
    tick();
    n_checks++;
    if (deal_count !== 3'd2) $display("FAIL last_lock_cycle: got %0d want 2", deal_count);
    else n_pass++;
    deal_btn = 1'b0;
    tick();
    deal_btn = 1'b1;
    tick();
    deal_btn = 1'b0;
    n_checks++;
    if (deal_count !== 3'd3) $display("FAIL after_lockout: got %0d want 3", deal_count);
    else n_pass++;
    n_checks++;
    if (dut_vec !== exp_vec()) $display("FAIL lockout_model: got %h want %h", dut_vec, exp_vec());
    else n_pass++;
    $display("test_lockout done: deal_count=%0d", deal_count);
  endtask

  task automatic test_new_hand();
    logic [3:0] v;
    do_reset();
    repeat (3) press_at(4'($urandom_range(1, CM)));
    n_checks++;
    if (deal_count !== 3'd3) $display("FAIL pre_new_hand: got %0d want 3", deal_count);
    else n_pass++;
    deal_btn = 1'b0;
    repeat (LK + 1) tick();
    deal_btn = 1'b1;
    new_hand = 1'b1;
    tick();
    deal_btn = 1'b0;
    new_hand = 1'b0;
    n_checks++;
    if (dut_vec[31:4] !== 28'd0) $display("FAIL new_hand_clear: got %h want 0", dut_vec[31:4]);
    else n_pass++;
    v = 4'($urandom_range(1, CM));
    press_at(v);
    n_checks++;
    if (pcard1 !== v || deal_count !== 3'd1)
      $display("FAIL after_new_hand: got p1=%0d cnt=%0d want p1=%0d cnt=1", pcard1, deal_count, v);
    else n_pass++;
    $display("test_new_hand done: pcard1=%0d deal_count=%0d", pcard1, deal_count);
  endtask

  task automatic test_reset_in_lock();
    do_reset();
    repeat (4) press_at(4'($urandom_range(1, CM)));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (dut_vec !== 32'd1) $display("FAIL reset_in_lock: got %h want %h", dut_vec, 32'd1);
    else n_pass++;
    $display("test_reset_in_lock done: card_value=%0d deal_count=%0d", card_value, deal_count);
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      deal_btn = ($urandom_range(0, 2) == 0);
      new_hand = ($urandom_range(0, 39) == 0);
      reset    = ($urandom_range(0, 299) == 0);
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        errs++;
        $display("FAIL random[%0d]: got %h want %h", i, dut_vec, exp_vec());
      end else n_pass++;
    end
    deal_btn = 1'b0;
    new_hand = 1'b0;
    reset    = 1'b0;
    $display("test_random done: 800 cycles, %0d discrepancies", errs);
  endtask

  initial begin
    reset    = 1'b1;
    deal_btn = 1'b0;
    new_hand = 1'b0;
    test_reset();
    test_hold_through_reset();
    test_full_hand();
    test_lockout();
    test_new_hand();
    test_reset_in_lock();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
